// File: rtl/uart_rx.sv
// uart_rx: UART receiver driven by a 16x oversampling tick.
//
// The asynchronous serial line is brought into the i_clk domain through a
// two-flop synchroniser. The FSM finds the start bit, samples each data bit
// in the middle of its bit period (LSB first), and checks the stop bit.
//
// Parameters:
//   DBIT    - data bits per frame (5..8)
//   SB_TICK - oversampling ticks in the stop period (16/24/32 = 1/1.5/2 stop bits)
//
// Ports:
//   i_clk          - system clock
//   i_reset        - synchronous, active-high reset
//   i_rx           - serial line, idle high, asynchronous to i_clk
//   i_s_tick       - one-cycle oversampling pulse at 16x baud
//   o_dout         - last received word, LSB = first bit on the line
//   o_rx_done_tick - one-cycle pulse when a frame completes
//   o_frame_err    - stop bit of the last completed frame was 0
//
// State   | Meaning
// --------+-----------------------------------------------------------
// IDLE    | line idle; waiting for synchronised rx to go low
// START   | counting 8 ticks to the middle of the start bit
// DATA    | sampling DBIT data bits, 16 ticks apart
// STOP    | waiting SB_TICK ticks, then sampling the stop bit
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
  output logic            o_frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic [4:0] S_MID      = 5'd7;
  localparam logic [4:0] S_BIT_LAST = 5'd15;
  localparam logic [4:0] S_STOP_END = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST     = 3'(DBIT - 1);

  state_e          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_s_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Leaving IDLE does not wait for a tick; only the line level matters.
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_q == S_STOP_END) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign o_dout         = dout_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (DBIT=8, SB_TICK=16).
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_s_tick = 1'b0;
  logic [7:0] o_dout;
  logic       o_rx_done_tick;
  logic       o_frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [7:0] dout_log [16];
  logic       ferr_log [16];

  // Tick spacing: 1 = every cycle; N > 1 = one tick every N cycles.
  // The spaced-tick case uses 40 rather than 326 to keep the run short;
  // the receiver behaviour only depends on ticks, not on the gap size.
  int tick_div = 1;
  int tick_phase = 0;
  localparam int TICK_DIV_SLOW = 40;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rx           (i_rx),
    .i_s_tick       (i_s_tick),
    .o_dout         (o_dout),
    .o_rx_done_tick (o_rx_done_tick),
    .o_frame_err    (o_frame_err)
  );

  initial forever #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (tick_div <= 1) begin
      i_s_tick = 1'b1;
    end else begin
      tick_phase = tick_phase + 1;
      if (tick_phase >= tick_div) tick_phase = 0;
      i_s_tick = (tick_phase == 0);
    end
  end

  always @(negedge i_clk) begin
    if (o_rx_done_tick) begin
      if (done_cnt < 16) begin
        dout_log[done_cnt] = o_dout;
        ferr_log[done_cnt] = o_frame_err;
      end
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; drives a whole frame, LSB first, and returns
  // at the falling edge that ends the stop bit with the line idle again.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int cpb);
    i_rx = 1'b0;
    start_cyc = cyc;
    repeat (cpb) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = data[i];
      repeat (cpb) @(negedge i_clk);
    end
    i_rx = stop;
    repeat (cpb) @(negedge i_clk);
    i_rx = 1'b1;
  endtask

  initial begin
    // Reset
    i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    check("reset_dout", 32'(o_dout), 32'h00);
    check("reset_done", 32'(o_rx_done_tick), 32'h0);
    check("reset_ferr", 32'(o_frame_err), 32'h0);
    repeat (200) @(negedge i_clk);
    check("reset_no_pulse", done_cnt, 0);

    // Nominal 0x55, tick every cycle
    send_frame(8'h55, 1'b1, 16);
    repeat (20) @(negedge i_clk);
    check("nom_count", done_cnt, 1);
    check("nom_latency", done_cyc - start_cyc, 155);
    check("nom_dout", 32'(o_dout), 32'h55);
    check("nom_ferr", 32'(o_frame_err), 32'h0);
    check("nom_done_low", 32'(o_rx_done_tick), 32'h0);

    // Framing error, then a good frame clears the flag
    send_frame(8'h3C, 1'b0, 16);
    repeat (40) @(negedge i_clk);
    check("ferr_count", done_cnt, 2);
    check("ferr_dout", 32'(o_dout), 32'h3C);
    check("ferr_flag", 32'(o_frame_err), 32'h1);
    send_frame(8'hC3, 1'b1, 16);
    repeat (40) @(negedge i_clk);
    check("good_count", done_cnt, 3);
    check("good_dout", 32'(o_dout), 32'hC3);
    check("good_ferr", 32'(o_frame_err), 32'h0);

    // Glitch: 4 cycles low is rejected at mid start bit
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (40) @(negedge i_clk);
    check("glitch_no_pulse", done_cnt, 3);
    check("glitch_dout_held", 32'(o_dout), 32'hC3);
    send_frame(8'h81, 1'b1, 16);
    repeat (40) @(negedge i_clk);
    check("post_glitch_count", done_cnt, 4);
    check("post_glitch_dout", 32'(o_dout), 32'h81);

    // Spaced ticks, back-to-back frames
    tick_div = TICK_DIV_SLOW;
    repeat (100) @(negedge i_clk);
    send_frame(8'hA5, 1'b1, 16 * TICK_DIV_SLOW);
    send_frame(8'h0F, 1'b1, 16 * TICK_DIV_SLOW);
    repeat (400) @(negedge i_clk);
    check("slow_count", done_cnt, 6);
    check("slow_dout0", 32'(dout_log[4]), 32'hA5);
    check("slow_ferr0", 32'(ferr_log[4]), 32'h0);
    check("slow_dout1", 32'(dout_log[5]), 32'h0F);
    check("slow_ferr1", 32'(ferr_log[5]), 32'h0);
    tick_div = 1;
    repeat (20) @(negedge i_clk);

    // Reset in the middle of 0xFF, after start + 3 data bits
    i_rx = 1'b0;
    repeat (16) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (48) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    check("midrst_dout", 32'(o_dout), 32'h00);
    check("midrst_ferr", 32'(o_frame_err), 32'h0);
    check("midrst_done", 32'(o_rx_done_tick), 32'h0);
    repeat (200) @(negedge i_clk);
    check("midrst_no_pulse", done_cnt, 6);
    send_frame(8'h7E, 1'b1, 16);
    repeat (40) @(negedge i_clk);
    check("after_rst_count", done_cnt, 7);
    check("after_rst_dout", 32'(o_dout), 32'h7E);
    check("after_rst_ferr", 32'(o_frame_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link. It consumes the 16x-oversampling tick from the baud-rate generator, so `i_s_tick` comes from the generator's `o_max_tick`. It synchronises the asynchronous `i_rx` line, detects the start bit, and samples each data bit at mid-bit, LSB first. It then presents the received byte with a one-cycle done pulse and a framing-error flag to the downstream FIFO/interface logic.

## Interface
- `DBIT`, default 8: data bits per frame (5..8).
- `SB_TICK`, default 16: oversampling ticks for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2; max 32).
- `i_clk`, input, 1: system clock. Single clock domain.
- `i_reset`, input, 1: reset. Synchronous, active-high.
- `i_rx`, input, 1: serial line, idle high, asynchronous to `i_clk`.
- `i_s_tick`, input, 1: oversampling enable. One-cycle pulse at 16x baud. May be high every cycle.
- `o_dout`, output, DBIT: last received data word, LSB = first bit on the line.
- `o_rx_done_tick`, output, 1: one-cycle pulse when a frame completes.
- `o_frame_err`, output, 1: stop-bit value of the last completed frame was 0. Valid with and after `o_rx_done_tick`.

## Operation
- `i_rx` passes through a 2-flop synchroniser (`rx_s`); reset value 1. All FSM decisions use `rx_s`.
- Internal registers:
  - tick counter `s`, 5 bits.
  - bit counter `n`, 3 bits.
  - shift register `b`, DBIT bits.
  - state register.
- States and transitions:
  - **IDLE**: if `rx_s == 0`, go to START with `s = 0`. Ticks are ignored in IDLE.
  - **START**: on each tick, if `s == 7`:
    - if `rx_s == 0`, go to DATA with `s = 0`, `n = 0`;
    - else return to IDLE (glitch rejected, no outputs change).
    - Otherwise `s++`.
  - **DATA**: on each tick, if `s == 15`:
    - `s = 0` and `b = {rx_s, b[DBIT-1:1]}`;
    - if `n == DBIT-1`, go to STOP;
    - else `n++`.
    - Otherwise `s++`.
  - **STOP**: on each tick, if `s == SB_TICK-1`, go to IDLE and, at the same edge:
    - `o_dout <= b`;
    - `o_frame_err <= ~rx_s`;
    - `o_rx_done_tick <= 1`.
    - Otherwise `s++`.
- `o_rx_done_tick` is registered. It is high for exactly one cycle and cleared on the next edge.
- `o_dout` and `o_frame_err` hold their values until the next completed frame or reset.
- A frame with a bad stop bit still delivers `o_dout` and a done pulse, with `o_frame_err = 1`.
- Cycles with `i_s_tick = 0` freeze `s`, `n`, `b` and the state, except IDLE, whose exit depends only on `rx_s`.
- Line held low indefinitely (break): one frame completes with `o_frame_err = 1`. The FSM then re-enters START immediately because `rx_s == 0`. Documented behaviour, not an error.

## Timing
- Reset (synchronous, takes priority over every other event):
  - state = IDLE;
  - `s`, `n`, `b` = 0;
  - `o_dout` = 0, `o_rx_done_tick` = 0, `o_frame_err` = 0;
  - synchroniser flops = 1.
- Reset asserted mid-frame aborts the frame with no done pulse.
- Input latency: 2 cycles through the synchroniser, plus 1 cycle for IDLE detection.
- Sample points: start bit is checked at tick 8; data bits at ticks 8+16k; stop bit at tick 8+16·DBIT+SB_TICK (counted from START entry).
- With `i_s_tick` high every cycle, DBIT=8 and SB_TICK=16, the done pulse follows a fixed edge count. Edge 1 is the first rising edge sampling `i_rx = 0`. `o_rx_done_tick` is high in the cycle after edge 155.
- Back-to-back frames: a start bit beginning immediately after the stop bit is received without loss.

## Test plan
- **Reset**: hold `i_reset` for 3 cycles with `i_rx = 1` → `o_dout = 0`, `o_rx_done_tick = 0`, `o_frame_err = 0`. No pulse for 200 cycles after release.
- **Nominal frame**: tick every cycle, send 0x55 with stop = 1 → a single done pulse in the cycle after edge 155, `o_dout = 0x55`, `o_frame_err = 0`.
- **Framing error**: send 0x3C with stop bit = 0 → done pulse, `o_dout = 0x3C`, `o_frame_err = 1`. A following good 0xC3 frame → `o_frame_err = 0`.
- **Glitch**: `i_rx` low for 4 cycles, tick every cycle → no done pulse, FSM back in IDLE. A subsequent frame 0x81 is received correctly.
- **Realistic ticks**: `i_s_tick` every 326 cycles, baud = 16·326 cycles/bit, back-to-back 0xA5 then 0x0F → two done pulses, `o_dout` = 0xA5 then 0x0F, no errors.
- **Reset mid-frame**: assert `i_reset` during DATA (after 3 bits of 0xFF) → no done pulse, outputs 0. The next frame 0x7E gives `o_dout = 0x7E`.
